instr_encoder: RTL and testbench
================================

# instr_encoder

Packs decoded instruction fields into 32-bit block instruction words and writes them sequentially into a processing block's instruction memory. It sits between the configuration/program loader and the per-block instruction RAM, and is the write-side counterpart of the block's instruction decoder. It validates each field record, selects the word format from the opcode class, and reports completion or a sticky error to the loader.

## Interface

**Parameters**
- `N_INSTRS`, 256: instruction memory depth; address width is `$clog2(N_INSTRS)`.
- `N_OPS`, 32: number of legal opcodes. Any `op >= N_OPS` is illegal.

**Ports**
- `clk`, input, 1: sole clock.
- `reset_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: one-cycle pulse. Clears the address counter, error, and done flags; enters LOAD.
- `in_valid`, input, 1: field record valid.
- `in_ready`, output, 1: encoder accepts the record this cycle.
- `in_last`, input, 1: this record is the final instruction of the program.
- `op`, input, 5: opcode.
- `src_a`, `src_b`, `src_c`, input, 5 each: `{reg_flag, index[3:0]}`.
- `dest`, input, 4: destination.
- `shift`, input, 5: shift amount.
- `saturate_disable`, `shift_disable`, input, 1 each: modifier flags.
- `res_addr`, input, 12: resource address (delay/LUT/mem).
- `mem_busy`, input, 1: instruction RAM write port unavailable this cycle.
- `wr_en`, output, 1: instruction RAM write strobe.
- `wr_addr`, output, `$clog2(N_INSTRS)`: write address.
- `wr_data`, output, 32: encoded word.
- `done`, output, 1: level signal, program fully written.
- `n_written`, output, `$clog2(N_INSTRS)+1`: count of words written.
- `err`, output, 1: sticky error.
- `err_code`, output, 2: 0 = none, 1 = illegal opcode, 2 = overflow, 3 = field conflict.

## Operation

- **States**
  - IDLE → LOAD on `start`.
  - LOAD → DONE after the word tagged `in_last` is written.
  - LOAD → ERROR on any check failure.
  - DONE and ERROR → LOAD on `start`.
  - `start` in any state restarts; an in-flight pipeline word is discarded.
- **Resource opcodes** (DELAY_READ, DELAY_WRITE, LUT_READ, MEM_READ, MEM_WRITE) use format 1. All others use format 0.
- **Format 0 word**
  - `[4:0]`=op, `[5]`=0, `[10:6]`=src_a, `[15:11]`=src_b, `[20:16]`=src_c.
  - `[24:21]`=dest, `[29:25]`=shift, `[30]`=saturate_disable, `[31]`=shift_disable.
- **Format 1 word**
  - `[4:0]`=op, `[5]`=1, `[10:6]`=src_a, `[15:11]`=src_b, `[19:16]`=dest, `[31:20]`=res_addr.
  - `shift`, `saturate_disable`, and `shift_disable` are ignored.
- **Checks** are performed in stage 1, with priority in this order:
  1. Illegal opcode (`op >= N_OPS`) → code 1.
  2. Write count already equal to `N_INSTRS` → code 2.
  3. Format-1 record with `src_c != 0` or `shift != 0` → code 3.
- **On error**
  - The offending word is not written.
  - `err` and `err_code` hold until `start` or reset.
  - `in_ready` stays 0.
- `wr_addr` starts at 0 and increments by 1 per write. It never wraps; overflow raises an error instead.

## Timing

- **Pipeline:** stage 0 is the input register; stage 1 encodes, checks, and drives `wr_*`. `wr_en` asserts 2 cycles after the accepting handshake, absent stalls.
- **Handshake**
  - A transfer occurs when `in_valid && in_ready`.
  - `in_ready` = state is LOAD && no error && (stage 0 empty || stage 0 advancing).
  - While `mem_busy`=1, stage 1 holds, `wr_en`=0, and full stages do not accept.
  - Full throughput of 1 word/cycle when `mem_busy`=0.
- After an `in_last` record is accepted, `in_ready`=0 until it is written. `done` rises the cycle after its `wr_en`.
- `start` coincident with `in_valid`: `start` wins and the record is not accepted.
- **Reset values:** `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `n_written`=0, `err`=0, `err_code`=0, state IDLE.

## Structure

- Shared package/include holds:
  - opcode constants;
  - the resource-opcode predicate;
  - format bit positions;
  - the state enum;
  - error-code constants.
- One natural sub-module, `instr_word_pack`: combinational, takes fields and format, returns the 32-bit word. It is reused by bench reference models.

## Test plan

- **Format 0 pack:** MADD, src_a=5'b10011, src_b=5'b00010, src_c=5'b10000, dest=5, shift=3, sat_dis=0, shift_dis=1 → `wr_data` = 32'h86B014C0 | MADD, `wr_addr`=0, two cycles after handshake.
- **Format 1 pack:** LUT_READ, src_a=5'b00100, dest=7, res_addr=12'hABC → `wr_data` = 32'hABC70120 | LUT_READ.
- **Back-to-back stream with stall:** 4 records back-to-back, `in_last` on the 4th, `mem_busy` high for 3 cycles mid-stream → addresses 0..3 each written once, in order, no drops; `done`=1 and `n_written`=4.
- **Overflow:** `N_INSTRS`=4 with a 5th record and no `in_last` → 4 writes, then `err_code`=2, `in_ready`=0, no 5th `wr_en`.
- **Error and restart:** format-1 record with shift=1 → `err_code`=3 and no write; a following `start` clears `err`, and the next record writes to address 0.
- **Reset mid-stream:** `reset_n` low while stage 1 is full → `wr_en`=0 the next cycle and all outputs at reset values.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - opcodes, word layout, states and error codes shared by the encoder
package instr_encoder_pkg;

  localparam logic [4:0] OP_NOP         = 5'd0;
  localparam logic [4:0] OP_ADD         = 5'd1;
  localparam logic [4:0] OP_SUB         = 5'd2;
  localparam logic [4:0] OP_MUL         = 5'd3;
  localparam logic [4:0] OP_MADD        = 5'd4;
  localparam logic [4:0] OP_SHL         = 5'd5;
  localparam logic [4:0] OP_SHR         = 5'd6;
  localparam logic [4:0] OP_MIN         = 5'd7;
  localparam logic [4:0] OP_MAX         = 5'd8;
  localparam logic [4:0] OP_DELAY_READ  = 5'd16;
  localparam logic [4:0] OP_DELAY_WRITE = 5'd17;
  localparam logic [4:0] OP_LUT_READ    = 5'd18;
  localparam logic [4:0] OP_MEM_READ    = 5'd19;
  localparam logic [4:0] OP_MEM_WRITE   = 5'd20;

  localparam int OP_LSB        = 0;
  localparam int FMT_BIT       = 5;
  localparam int SRC_A_LSB     = 6;
  localparam int SRC_B_LSB     = 11;
  localparam int SRC_C_LSB     = 16;
  localparam int F0_DEST_LSB   = 21;
  localparam int SHIFT_LSB     = 25;
  localparam int SAT_DIS_BIT   = 30;
  localparam int SHIFT_DIS_BIT = 31;
  localparam int F1_DEST_LSB   = 16;
  localparam int RES_LSB       = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW   = 2'd2;
  localparam logic [1:0] ERR_CONFLICT   = 2'd3;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [4:0]  src_c;
    logic [3:0]  dest;
    logic [4:0]  shift;
    logic        saturate_disable;
    logic        shift_disable;
    logic [11:0] res_addr;
    logic        last;
  } rec_t;

  // Resource opcodes carry a 12-bit resource address and use format 1.
  function automatic logic is_resource_op(input logic [4:0] op);
    return op inside {OP_DELAY_READ, OP_DELAY_WRITE, OP_LUT_READ, OP_MEM_READ, OP_MEM_WRITE};
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// rtl/instr_word_pack.sv - combinational packer from instruction fields to a 32-bit word
module instr_word_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  input  logic [4:0]  src_c,
  input  logic [3:0]  dest,
  input  logic [4:0]  shift,
  input  logic        saturate_disable,
  input  logic        shift_disable,
  input  logic [11:0] res_addr,
  input  logic        fmt,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    word[OP_LSB +: 5]    = op;
    word[FMT_BIT]        = fmt;
    word[SRC_A_LSB +: 5] = src_a;
    word[SRC_B_LSB +: 5] = src_b;
    if (fmt) begin
      word[F1_DEST_LSB +: 4] = dest;
      word[RES_LSB +: 12]    = res_addr;
    end else begin
      word[SRC_C_LSB +: 5]   = src_c;
      word[F0_DEST_LSB +: 4] = dest;
      word[SHIFT_LSB +: 5]   = shift;
      word[SAT_DIS_BIT]      = saturate_disable;
      word[SHIFT_DIS_BIT]    = shift_disable;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage encoder writing packed instruction words into block RAM
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int N_INSTRS = 256,
  parameter int N_OPS    = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [4:0]                  op,
  input  logic [4:0]                  src_a,
  input  logic [4:0]                  src_b,
  input  logic [4:0]                  src_c,
  input  logic [3:0]                  dest,
  input  logic [4:0]                  shift,
  input  logic                        saturate_disable,
  input  logic                        shift_disable,
  input  logic [11:0]                 res_addr,
  input  logic                        mem_busy,
  output logic                        wr_en,
  output logic [$clog2(N_INSTRS)-1:0] wr_addr,
  output logic [31:0]                 wr_data,
  output logic                        done,
  output logic [$clog2(N_INSTRS):0]   n_written,
  output logic                        err,
  output logic [1:0]                  err_code
);

  localparam int              AW         = $clog2(N_INSTRS);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(N_INSTRS);
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(N_INSTRS - 1);

  logic [1:0]  state;
  rec_t        in_rec, s0, s1;
  logic        s0_valid, s1_valid, last_seen;
  logic        load, fmt, chk_fail, s1_adv;
  logic [1:0]  chk_code;
  logic [31:0] word;

  always_comb begin
    in_rec = '{op: op, src_a: src_a, src_b: src_b, src_c: src_c, dest: dest, shift: shift,
               saturate_disable: saturate_disable, shift_disable: shift_disable,
               res_addr: res_addr, last: in_last};
  end

  assign fmt = is_resource_op(s1.op);

  instr_word_pack u_pack (
    .op               (s1.op),
    .src_a            (s1.src_a),
    .src_b            (s1.src_b),
    .src_c            (s1.src_c),
    .dest             (s1.dest),
    .shift            (s1.shift),
    .saturate_disable (s1.saturate_disable),
    .shift_disable    (s1.shift_disable),
    .res_addr         (s1.res_addr),
    .fmt              (fmt),
    .word             (word)
  );

  // Checks act on the word about to be written, so the overflow test sees the live count.
  always_comb begin
    chk_code = ERR_NONE;
    if (int'(s1.op) >= N_OPS)                             chk_code = ERR_ILLEGAL_OP;
    else if (n_written == FULL_COUNT)                     chk_code = ERR_OVERFLOW;
    else if (fmt && (s1.src_c != '0 || s1.shift != '0))   chk_code = ERR_CONFLICT;
  end

  assign load     = (state == ST_LOAD);
  assign chk_fail = load && s1_valid && (chk_code != ERR_NONE);
  assign wr_en    = load && s1_valid && (chk_code == ERR_NONE) && !mem_busy && !start;
  assign s1_adv   = !s1_valid || wr_en;
  assign in_ready = load && !start && !chk_fail && !last_seen && (!s0_valid || s1_adv);
  assign wr_data  = s1_valid ? word : '0;
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERROR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      s0        <= '0;
      s1        <= '0;
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      last_seen <= 1'b0;
      n_written <= '0;
      wr_addr   <= '0;
      err_code  <= ERR_NONE;
    end else if (start) begin
      state     <= ST_LOAD;
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      last_seen <= 1'b0;
      n_written <= '0;
      wr_addr   <= '0;
      err_code  <= ERR_NONE;
    end else begin
      if (in_valid && in_ready) begin
        s0       <= in_rec;
        s0_valid <= 1'b1;
        if (in_last) last_seen <= 1'b1;
      end else if (s0_valid && s1_adv) begin
        s0_valid <= 1'b0;
      end
      if (s1_adv) begin
        s1_valid <= s0_valid;
        s1       <= s0;
      end
      if (wr_en) begin
        n_written <= n_written + 1'b1;
        if (wr_addr != LAST_ADDR) wr_addr <= wr_addr + 1'b1;
        if (s1.last) state <= ST_DONE;
      end
      if (chk_fail) begin
        state    <= ST_ERROR;
        err_code <= chk_code;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed and randomized checks of instr_encoder against a field-level model
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  src_a, src_b, src_c;
    logic [3:0]  dest;
    logic [4:0]  shift;
    logic        sat_dis, sh_dis;
    logic [11:0] res_addr;
    logic        last;
  } trec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, mem_busy = 1'b0;
  logic [4:0] op = '0, src_a = '0, src_b = '0, src_c = '0, shift = '0;
  logic [3:0] dest = '0;
  logic saturate_disable = 1'b0, shift_disable = 1'b0;
  logic [11:0] res_addr = '0;
  logic sel = 1'b0;

  logic a_in_ready, a_wr_en, a_done, a_err;
  logic [7:0] a_wr_addr; logic [31:0] a_wr_data; logic [8:0] a_n_written; logic [1:0] a_err_code;
  logic b_in_ready, b_wr_en, b_done, b_err;
  logic [1:0] b_wr_addr; logic [31:0] b_wr_data; logic [2:0] b_n_written; logic [1:0] b_err_code;

  logic in_ready_m, wr_en_m, done_m, err_m;
  logic [7:0] wr_addr_m; logic [31:0] wr_data_m; logic [8:0] n_written_m; logic [1:0] err_code_m;

  int n_cmp = 0, n_bad = 0, cyc = 0, first_hs = 0;
  trec_t stim[$];
  logic [7:0] obs_addr[$]; logic [31:0] obs_data[$]; int obs_cyc[$];

  instr_encoder #(.N_INSTRS(256), .N_OPS(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_last(in_last), .op(op), .src_a(src_a), .src_b(src_b), .src_c(src_c), .dest(dest),
    .shift(shift), .saturate_disable(saturate_disable), .shift_disable(shift_disable),
    .res_addr(res_addr), .mem_busy(mem_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .done(a_done), .n_written(a_n_written), .err(a_err), .err_code(a_err_code));

  instr_encoder #(.N_INSTRS(4), .N_OPS(24)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_last(in_last), .op(op), .src_a(src_a), .src_b(src_b), .src_c(src_c), .dest(dest),
    .shift(shift), .saturate_disable(saturate_disable), .shift_disable(shift_disable),
    .res_addr(res_addr), .mem_busy(mem_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .done(b_done), .n_written(b_n_written), .err(b_err), .err_code(b_err_code));

  assign in_ready_m  = sel ? b_in_ready : a_in_ready;
  assign wr_en_m     = sel ? b_wr_en : a_wr_en;
  assign wr_addr_m   = sel ? {6'b0, b_wr_addr} : a_wr_addr;
  assign wr_data_m   = sel ? b_wr_data : a_wr_data;
  assign done_m      = sel ? b_done : a_done;
  assign n_written_m = sel ? {6'b0, b_n_written} : a_n_written;
  assign err_m       = sel ? b_err : a_err;
  assign err_code_m  = sel ? b_err_code : a_err_code;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #3;
    if (wr_en_m) begin
      obs_addr.push_back(wr_addr_m);
      obs_data.push_back(wr_data_m);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit is_res(input logic [4:0] o);
    return o == OP_DELAY_READ || o == OP_DELAY_WRITE || o == OP_LUT_READ ||
           o == OP_MEM_READ || o == OP_MEM_WRITE;
  endfunction

  // Word layout computed by weighting each field with its bit position.
  function automatic logic [31:0] ref_word(input trec_t r);
    if (is_res(r.op))
      return 32'(r.op) + 32'd32 + 32'(r.src_a) * 32'd64 + 32'(r.src_b) * 32'd2048 +
             32'(r.dest) * 32'h10000 + 32'(r.res_addr) * 32'h100000;
    return 32'(r.op) + 32'(r.src_a) * 32'd64 + 32'(r.src_b) * 32'd2048 + 32'(r.src_c) * 32'h10000 +
           32'(r.dest) * 32'h200000 + 32'(r.shift) * 32'h2000000 +
           32'(r.sat_dis) * 32'h40000000 + 32'(r.sh_dis) * 32'h80000000;
  endfunction

  function automatic trec_t mk(input logic [4:0] o, input logic [4:0] sa, input logic [4:0] sb,
                               input logic [4:0] sc, input logic [3:0] d, input logic [4:0] sh,
                               input logic sat, input logic sd, input logic [11:0] ra,
                               input logic lst);
    trec_t r;
    r.op = o; r.src_a = sa; r.src_b = sb; r.src_c = sc; r.dest = d; r.shift = sh;
    r.sat_dis = sat; r.sh_dis = sd; r.res_addr = ra; r.last = lst;
    return r;
  endfunction

  function automatic trec_t rand_rec(input bit res, input int nops, input logic lst);
    trec_t r;
    logic [4:0] o;
    if (res) begin
      case ($urandom_range(0, 4))
        0: o = OP_DELAY_READ;
        1: o = OP_DELAY_WRITE;
        2: o = OP_LUT_READ;
        3: o = OP_MEM_READ;
        default: o = OP_MEM_WRITE;
      endcase
    end else begin
      do o = 5'($urandom_range(0, nops - 1)); while (is_res(o));
    end
    r = mk(o, 5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom), 5'($urandom),
           1'($urandom), 1'($urandom), 12'($urandom), lst);
    if (res) begin
      r.src_c = '0;
      r.shift = '0;
    end
    return r;
  endfunction

  task automatic drive(input trec_t r);
    op = r.op; src_a = r.src_a; src_b = r.src_b; src_c = r.src_c; dest = r.dest;
    shift = r.shift; saturate_disable = r.sat_dis; shift_disable = r.sh_dis;
    res_addr = r.res_addr; in_last = r.last;
  endtask

  task automatic do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
  endtask

  task automatic run_stream(input bit rnd_busy, input int busy_lo, input int busy_hi);
    int idx = 0;
    int t = 0;
    while (idx < stim.size() && !err_m && t < 3000) begin
      tick();
      drive(stim[idx]);
      in_valid = 1'b1;
      mem_busy = rnd_busy ? ($urandom_range(0, 3) == 0) : (t >= busy_lo && t < busy_hi);
      #1;
      if (in_ready_m) begin
        if (idx == 0) first_hs = cyc;
        idx++;
      end
      t++;
    end
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    t = 0;
    while (!done_m && !err_m && t < 300) begin
      mem_busy = rnd_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
      t++;
    end
    check("stream_finished", 32'(done_m | err_m), 32'd1);
    mem_busy = 1'b0;
    repeat (3) tick();
  endtask

  // Walks the records in order applying the check priority; writes stop at the first fault or last.
  task automatic check_stream(input string tag, input int nmax, input int nops);
    int cnt = 0;
    int ecode = 0;
    bit dn = 0;
    logic [31:0] exp_data[$];
    foreach (stim[i]) begin
      if (int'(stim[i].op) >= nops) begin ecode = 1; break; end
      if (cnt == nmax) begin ecode = 2; break; end
      if (is_res(stim[i].op) && (stim[i].src_c != 0 || stim[i].shift != 0)) begin ecode = 3; break; end
      exp_data.push_back(ref_word(stim[i]));
      cnt++;
      if (stim[i].last) begin dn = 1; break; end
    end
    check({tag, "_writes"}, obs_data.size(), cnt);
    for (int i = 0; i < cnt && i < obs_data.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[i]), i);
      check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    check({tag, "_done"}, 32'(done_m), 32'(dn));
    check({tag, "_err"}, 32'(err_m), 32'(ecode != 0));
    check({tag, "_err_code"}, 32'(err_code_m), ecode);
    check({tag, "_n_written"}, 32'(n_written_m), cnt);
    check({tag, "_in_ready"}, 32'(in_ready_m), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_m), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en_m), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr_m), 32'd0);
    check({tag, "_wr_data"}, wr_data_m, 32'd0);
    check({tag, "_done"}, 32'(done_m), 32'd0);
    check({tag, "_n_written"}, 32'(n_written_m), 32'd0);
    check({tag, "_err"}, 32'(err_m), 32'd0);
    check({tag, "_err_code"}, 32'(err_code_m), 32'd0);
  endtask

  initial begin
    trec_t r;
    int n, bad_at;

    repeat (3) tick();
    reset_n = 1'b1;
    drive(mk(OP_ADD, 5'd1, 5'd2, 5'd3, 4'd4, 5'd0, 1'b0, 1'b0, 12'd0, 1'b0));
    in_valid = 1'b1;
    tick();
    check_reset_outputs("reset");
    in_valid = 1'b0;

    // Format 0 packing and two-cycle latency.
    do_start();
    stim = '{mk(OP_MADD, 5'b10011, 5'b00010, 5'b10000, 4'd5, 5'd3, 1'b0, 1'b1, 12'h000, 1'b1)};
    run_stream(1'b0, 0, 0);
    check("fmt0_writes", obs_data.size(), 1);
    if (obs_data.size() > 0) begin
      check("fmt0_data", obs_data[0], 32'h86B014C0 | 32'(OP_MADD));
      check("fmt0_addr", 32'(obs_addr[0]), 32'd0);
      check("fmt0_latency", obs_cyc[0] - first_hs, 32'd2);
    end
    check("fmt0_done", 32'(done_m), 32'd1);

    // Format 1 packing; shift/saturate flags of a resource op are ignored.
    do_start();
    stim = '{mk(OP_LUT_READ, 5'b00100, 5'b00000, 5'd0, 4'd7, 5'd0, 1'b1, 1'b1, 12'hABC, 1'b1)};
    run_stream(1'b0, 0, 0);
    check("fmt1_writes", obs_data.size(), 1);
    if (obs_data.size() > 0) check("fmt1_data", obs_data[0], 32'hABC70120 | 32'(OP_LUT_READ));

    // Back-to-back four records with a three-cycle RAM stall mid-stream.
    do_start();
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(rand_rec(i[0], 32, i == 3));
    run_stream(1'b0, 2, 5);
    check_stream("stall4", 256, 32);

    // Random streams with random stalls, some carrying a field conflict.
    for (int k = 0; k < 5; k++) begin
      do_start();
      stim.delete();
      n = $urandom_range(5, 16);
      bad_at = ($urandom_range(0, 1) == 0) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < n; i++) begin
        r = rand_rec($urandom_range(0, 2) == 0, 32, i == n - 1);
        if (i == bad_at) begin
          r = rand_rec(1'b1, 32, i == n - 1);
          if ($urandom_range(0, 1) == 0) r.shift = 5'($urandom_range(1, 31));
          else r.src_c = 5'($urandom_range(1, 31));
        end
        stim.push_back(r);
      end
      run_stream(1'b1, 0, 0);
      check_stream($sformatf("rand%0d", k), 256, 32);
    end

    // Field conflict, then restart with start colliding with a valid record.
    do_start();
    stim = '{mk(OP_LUT_READ, 5'd1, 5'd2, 5'd0, 4'd3, 5'd1, 1'b0, 1'b0, 12'h123, 1'b1)};
    run_stream(1'b0, 0, 0);
    check_stream("conflict", 256, 32);
    tick();
    drive(mk(OP_ADD, 5'd9, 5'd8, 5'd7, 4'd6, 5'd5, 1'b0, 1'b0, 12'd0, 1'b1));
    in_valid = 1'b1;
    start = 1'b1;
    #1;
    check("start_wins_in_ready", 32'(in_ready_m), 32'd0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    check("restart_err", 32'(err_m), 32'd0);
    check("restart_err_code", 32'(err_code_m), 32'd0);
    repeat (4) tick();
    check("start_wins_no_write", obs_data.size(), 0);
    stim = '{mk(OP_SUB, 5'd17, 5'd3, 5'd30, 4'd2, 5'd9, 1'b1, 1'b0, 12'd0, 1'b1)};
    run_stream(1'b0, 0, 0);
    check_stream("after_restart", 256, 32);

    // Small instance: overflow on the fifth record, then an illegal opcode.
    sel = 1'b1;
    do_start();
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(rand_rec(i == 2, 24, 1'b0));
    run_stream(1'b0, 1, 3);
    check_stream("overflow", 4, 24);
    do_start();
    stim = '{mk(5'd30, 5'd1, 5'd1, 5'd1, 4'd1, 5'd1, 1'b0, 1'b0, 12'd0, 1'b1)};
    run_stream(1'b0, 0, 0);
    check_stream("illegal_op", 4, 24);
    sel = 1'b0;

    // Reset while stage 1 holds a word behind a busy RAM.
    do_start();
    r = mk(OP_MUL, 5'd21, 5'd6, 5'd11, 4'd9, 5'd4, 1'b1, 1'b1, 12'd0, 1'b0);
    tick();
    drive(r);
    in_valid = 1'b1;
    mem_busy = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("held_wr_en", 32'(wr_en_m), 32'd0);
    check("held_wr_data", wr_data_m, ref_word(r));
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    mem_busy = 1'b0;
    repeat (3) tick();
    check("midreset_no_write", obs_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
